io_uart_tx: RTL and testbench
=============================

Name: io_uart_tx

Overview:
- Output-port peripheral directly downstream of the single-cycle CPU; consumes its I/O-write bus.
- CPU writes bytes to the data register; they are buffered in a small FIFO and shifted out serially as 8N1 frames.
- Status register is readable over the same port; the CPU polls it before writing.

Parameters:
- FIFO_DEPTH, 4, byte entries in the TX FIFO; power of two, at least 2.
- CLK_DIV, 16, clock cycles per serial bit; at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- io_we  input  1  CPU I/O write strobe, one cycle per write.
- io_addr  input  1  0 = data register, 1 = status/control register.
- io_wdata  input  8  write data from the CPU.
- io_rdata  output  8  read data, combinational from io_addr.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Reset (asynchronous, active-high; takes effect immediately, including mid-frame):
  - tx=1, busy=0, FIFO emptied, overflow=0, FSM=IDLE, bit and divider counters cleared.
  - A partially sent frame is abandoned; tx returns high at once.
- Write to the data register (io_we=1, io_addr=0):
  - Not full: byte is pushed at the edge.
  - Full and no pop in the same cycle: byte is dropped and sticky overflow is set.
  - Full and pop in the same cycle: push is accepted and occupancy is unchanged.
- Write to the status/control register (io_we=1, io_addr=1): io_wdata[2]=1 clears overflow. Other bits are ignored.
- Read data:
  - io_addr=0: io_rdata = 0.
  - io_addr=1: io_rdata = {4'b0, tx_active, overflow, full, empty}.
- FIFO: circular buffer with wrapping read/write pointers.
  - Occupancy counter 0..FIFO_DEPTH; empty = (count==0), full = (count==FIFO_DEPTH).
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START: on the first edge at which FIFO is non-empty. The head byte is popped into the shift register; tx=0 from that edge onward.
  - Example: a write at edge N into an empty FIFO with IDLE gives the START load at edge N+1.
  - START: held CLK_DIV cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLK_DIV cycles; bit counter 0..7. After bit 7 -> STOP.
  - STOP: tx=1 for CLK_DIV cycles.
  - End of STOP with FIFO non-empty: pop and go straight to START, no idle gap.
  - End of STOP with FIFO empty: go to IDLE.
  - Frame length is exactly 10*CLK_DIV cycles.
- tx_active = (FSM != IDLE); busy = tx_active | ~empty.
- The divider counter counts 0..CLK_DIV-1 and restarts on every state entry.

Optional Feature:
- Macro: IO_UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles.
  - Frame becomes 11*CLK_DIV cycles.
  - Status bit 4 reads 1 to flag parity support.
- Undefined: no PARITY state, 10-bit frames, status bit 4 reads 0.

Test Plan:
- Reset, CLK_DIV=4: tx=1, busy=0, status read = 8'h01. Assert reset mid-frame -> tx=1 in the same cycle, status returns to 8'h01.
- Write 8'hA5 at edge N: start bit low from edge N+1 for 4 cycles. Bits LSB first 1,0,1,0,0,1,0,1, 4 cycles each. Stop high for 4 cycles. busy drops at edge N+41.
- Four back-to-back writes 8'h01..8'h04, FIFO_DEPTH=4: the first is popped at the next edge, so it never fills. Four frames go out contiguous with no idle gap between stop and the next start, in order 01,02,03,04.
- Six writes in consecutive cycles while idle: five accepted (one already popped), the sixth sets overflow. Status bit 2 reads 1. Write 8'h04 to addr 1 -> bit 2 clears. Transmitted bytes exclude the sixth.
- Write at the exact cycle a STOP ends with FIFO full: push accepted, count stays 4, no overflow.
- With IO_UART_TX_PARITY_EN, write 8'h07: parity bit = 1 between bit 7 and stop, frame length 44 cycles. Write 8'h03: parity bit = 0.

Source files
------------

// File: rtl/io_uart_tx.sv
// CPU-write UART transmitter: FIFO-buffered 8N1 frames, or 8E1 when IO_UART_TX_PARITY_EN is defined.
// A write to a full FIFO with no pop in the same cycle is dropped and sets the sticky overflow flag.
module io_uart_tx #(
   parameter int FIFO_DEPTH = 4,
   parameter int CLK_DIV    = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       io_we,
   input  logic       io_addr,
   input  logic [7:0] io_wdata,
   output logic [7:0] io_rdata,
   output logic       tx,
   output logic       busy
);
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int DW     = $clog2(CLK_DIV);
   localparam int DIV_M1 = CLK_DIV - 1;
   localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
   localparam logic [DW-1:0] DIV_LAST = DIV_M1[DW-1:0];
`ifdef IO_UART_TX_PARITY_EN
   localparam logic PAR_FLAG = 1'b1;
`else
   localparam logic PAR_FLAG = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state;
   logic [DW-1:0] div_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
`ifdef IO_UART_TX_PARITY_EN
   logic          par;
`endif

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          overflow;
   logic          empty, full, div_last, pop, wr_data, push, tx_active;

   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign div_last  = (div_cnt == DIV_LAST);
   assign tx_active = (state != IDLE);
   assign busy      = tx_active | ~empty;
   // The FSM loads the head byte when idle or when a stop bit finishes, so pop is decided here.
   assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & div_last));
   assign wr_data   = io_we & ~io_addr;
   assign push      = wr_data & (~full | pop);

   always_comb begin
      io_rdata = 8'h00;
      if (io_addr)
         io_rdata = {3'b000, PAR_FLAG, tx_active, overflow, full, empty};
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= io_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
         if (wr_data && !push)
            overflow <= 1'b1;
         else if (io_we && io_addr && io_wdata[2])
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
`ifdef IO_UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
         tx      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               div_cnt <= '0;
               if (!empty) begin
                  state <= START;
                  shreg <= mem[rd_ptr];
`ifdef IO_UART_TX_PARITY_EN
                  par   <= ^mem[rd_ptr];
`endif
                  tx    <= 1'b0;
               end
            end
            START: begin
               if (div_last) begin
                  state   <= DATA;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  tx      <= shreg[0];
               end else
                  div_cnt <= div_cnt + 1'b1;
            end
            DATA: begin
               if (div_last) begin
                  div_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
                     state <= PARITY;
                     tx    <= par;
`else
                     state <= STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx      <= shreg[1];
                  end
               end else
                  div_cnt <= div_cnt + 1'b1;
            end
            PARITY: begin
               if (div_last) begin
                  state   <= STOP;
                  div_cnt <= '0;
                  tx      <= 1'b1;
               end else
                  div_cnt <= div_cnt + 1'b1;
            end
            STOP: begin
               if (div_last) begin
                  div_cnt <= '0;
                  // Back-to-back frames: the next start bit follows the stop bit with no idle gap.
                  if (!empty) begin
                     state <= START;
                     shreg <= mem[rd_ptr];
`ifdef IO_UART_TX_PARITY_EN
                     par   <= ^mem[rd_ptr];
`endif
                     tx    <= 1'b0;
                  end else
                     state <= IDLE;
               end else
                  div_cnt <= div_cnt + 1'b1;
            end
            default: begin
               state   <= IDLE;
               div_cnt <= '0;
               tx      <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: a frame-schedule model predicts each byte's start edge; a line monitor decodes and scores frames.
module tb_io_uart_tx;
   localparam int DIV   = 4;
   localparam int DEPTH = 4;
`ifdef IO_UART_TX_PARITY_EN
   localparam int NBITS = 11;
   localparam logic [7:0] PAR_FLAG = 8'h10;
`else
   localparam int NBITS = 10;
   localparam logic [7:0] PAR_FLAG = 8'h00;
`endif
   localparam int FRAME = NBITS * DIV;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       io_we = 1'b0;
   logic       io_addr = 1'b0;
   logic [7:0] io_wdata = 8'h00;
   logic [7:0] io_rdata;
   logic       tx;
   logic       busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Model: every accepted byte with its write edge and its scheduled start-bit edge.
   int         w_arr[$];
   int         s_arr[$];
   logic [7:0] exp_byte[$];
   int         exp_start[$];
   bit         model_ovf = 1'b0;
   bit         chk_en = 1'b0;
   bit         mon_en = 1'b0;

   io_uart_tx #(.FIFO_DEPTH(DEPTH), .CLK_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .io_we(io_we), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .tx(tx), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic wr(input logic a, input logic [7:0] d);
      int w, occ, st, last_end;
      bit popnow;
      @(negedge clk);
      io_we = 1'b1;
      io_addr = a;
      io_wdata = d;
      w = cyc + 1;
      if (a) begin
         if (d[2]) model_ovf = 1'b0;
      end else begin
         occ = 0;
         popnow = 1'b0;
         foreach (s_arr[i]) begin
            if (s_arr[i] >= w) occ++;
            if (s_arr[i] == w) popnow = 1'b1;
         end
         if (occ < DEPTH || popnow) begin
            last_end = (s_arr.size() == 0) ? 0 : s_arr[$] + FRAME;
            st = (last_end > w + 1) ? last_end : w + 1;
            w_arr.push_back(w);
            s_arr.push_back(st);
            exp_byte.push_back(d);
            exp_start.push_back(st);
         end else
            model_ovf = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         io_we = 1'b0;
         io_addr = 1'($urandom_range(0, 1));
         io_wdata = 8'($urandom);
      end
   endtask

   task automatic drain();
      int end_t;
      end_t = (s_arr.size() == 0) ? 0 : s_arr[$] + FRAME;
      if (end_t > cyc) idle(end_t - cyc + 3);
      else idle(3);
   endtask

   // Per-cycle status/busy check against the schedule, sampled just after each edge.
   always begin : chk_p
      int t, occ;
      bit act;
      logic [7:0] st;
      @(posedge clk);
      #1;
      if (chk_en) begin
         t = cyc;
         occ = 0;
         act = 1'b0;
         for (int i = 0; i < s_arr.size(); i++) begin
            if (w_arr[i] <= t && s_arr[i] > t) occ++;
            if (s_arr[i] <= t && t < s_arr[i] + FRAME) act = 1'b1;
         end
         st = {4'b0000, act, model_ovf, occ == DEPTH, occ == 0} | PAR_FLAG;
         check("busy", int'(busy), int'(act || occ > 0));
         check("rdata", int'(io_rdata), io_addr ? int'(st) : 0);
      end
   end

   // Line monitor: decodes each frame at mid-bit and scores it against the queue head.
   always begin : mon_p
      int t0, es;
      logic [7:0] b, eb;
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
         t0 = cyc;
         if (exp_byte.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: start bit at cycle %0d, expected no frame", t0);
         end else begin
            eb = exp_byte.pop_front();
            es = exp_start.pop_front();
            check("frame_start", t0, es);
            repeat (DIV / 2) @(negedge clk);
            check("start_bit", int'(tx), 0);
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               b[i] = tx;
            end
            check("data_byte", int'(b), int'(eb));
`ifdef IO_UART_TX_PARITY_EN
            repeat (DIV) @(negedge clk);
            check("parity_bit", int'(tx), int'(^eb));
`endif
            repeat (DIV) @(negedge clk);
            check("stop_bit", int'(tx), 1);
            repeat (DIV - DIV / 2 - 1) @(negedge clk);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
      $fatal(1);
   end

   initial begin
      int c, target;
      repeat (3) @(negedge clk);
      io_addr = 1'b1;
      #1;
      check("reset_tx", int'(tx), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_status", int'(io_rdata), int'(8'h01 | PAR_FLAG));
      @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
      mon_en = 1'b1;
      idle(4);

      wr(1'b0, 8'hA5);
      idle(FRAME + 10);

      for (int i = 1; i <= 4; i++) wr(1'b0, 8'(i));
      drain();

      for (int i = 0; i < 6; i++) wr(1'b0, 8'(8'h10 + i));
      idle(3);
      wr(1'b1, 8'h04);
      drain();

      // Fill the FIFO, then write on the exact edge a stop bit ends and the next byte pops.
      for (int i = 0; i < 5; i++) wr(1'b0, 8'(8'h30 + i));
      target = s_arr[s_arr.size() - 4];
      c = cyc;
      idle(target - c - 2);
      wr(1'b0, 8'h3F);
      idle(2);
      drain();

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) wr(1'b1, 8'h04);
         else wr(1'b0, 8'($urandom));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 60));
      end
      drain();
      check("queue_empty", exp_byte.size(), 0);

      chk_en = 1'b0;
      mon_en = 1'b0;
      wr(1'b0, 8'h00);
      idle(10);
      check("midframe_tx_low", int'(tx), 0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      io_addr = 1'b1;
      #1;
      check("midframe_reset_tx", int'(tx), 1);
      check("midframe_reset_busy", int'(busy), 0);
      check("midframe_reset_status", int'(io_rdata), int'(8'h01 | PAR_FLAG));
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_tx", int'(tx), 1);
      check("post_reset_status", int'(io_rdata), int'(8'h01 | PAR_FLAG));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
